// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder: aluop codes, field widths, FSM states.
package isa_pkg;

  localparam int unsigned IMM_BASE  = 19;
  localparam int unsigned ALUOP_MAX = 30;
  localparam int unsigned OPC_W     = 9;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned REG_W     = 3;

  // 0..6 keep their code, 7..15 shift by one, 16..18 by two, 19..30 are immediate-type.
  localparam logic [4:0]
    NOP  = 5'd0,  ADD  = 5'd1,  SUB  = 5'd2,  AND  = 5'd3,  OR   = 5'd4,  XOR  = 5'd5,
    NOT  = 5'd6,  MOV  = 5'd7,  SHL  = 5'd8,  SHR  = 5'd9,  CMP  = 5'd10, INC  = 5'd11,
    DEC  = 5'd12, PUSH = 5'd13, POP  = 5'd14, JR   = 5'd15, LD   = 5'd16, ST   = 5'd17,
    SWAP = 5'd18, LDI  = 5'd19, ADDI = 5'd20, SUBI = 5'd21, ANDI = 5'd22, ORI  = 5'd23,
    XORI = 5'd24, CMPI = 5'd25, JMP  = 5'd26, JZ   = 5'd27, JNZ  = 5'd28, OUTP = 5'd29,
    SHOWDMSEG = 5'd30;

  typedef enum logic [1:0] {StIdle, StRun, StFull} enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and memory-write output channels of the instruction encoder.
interface instr_encoder_if #(
  parameter int unsigned AW = 8
) ();
  import isa_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       aluop;
  logic [REG_W-1:0] op1;
  logic [REG_W-1:0] op2;
  logic [IMM_W-1:0] immdata;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_instr;
  logic [AW-1:0]    out_addr;

  modport master (
    output in_valid, aluop, op1, op2, immdata, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, aluop, op1, op2, immdata, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_enc_comb.sv
// Pure combinational packing of decoded fields into a 16-bit instruction word.
// Optional macro ENC_CHECK_EN adds the discarded-field-nonzero flag.
module instr_enc_comb
  import isa_pkg::*;
(
  input  logic [4:0]       aluop,
  input  logic [REG_W-1:0] op1,
  input  logic [REG_W-1:0] op2,
  input  logic [IMM_W-1:0] immdata,
`ifdef ENC_CHECK_EN
  output logic             discard_nz,
`endif
  output logic             legal,
  output logic [15:0]      instr
);

  logic [OPC_W-1:0] w_opc;
  logic [3:0]       w_imm_sel;

  assign w_imm_sel = 4'(aluop - 5'(IMM_BASE));

  // Map aluop to opcode and assemble register- or immediate-type word.
  always_comb begin
    legal = 1'b1;
    w_opc = '0;
    instr = '0;
    if (aluop == NOP) begin
      instr = '0;
    end else if (aluop <= NOT) begin
      w_opc = OPC_W'(aluop);
      instr = {1'b0, w_opc, op1, op2};
    end else if (aluop <= JR) begin
      w_opc = OPC_W'(aluop) + OPC_W'(1);
      instr = {1'b0, w_opc, op1, op2};
    end else if (aluop <= SWAP) begin
      w_opc = OPC_W'(aluop) + OPC_W'(2);
      instr = {1'b0, w_opc, op1, op2};
    end else if (aluop <= 5'(ALUOP_MAX)) begin
      instr = {1'b1, w_imm_sel, op1, immdata};
    end else begin
      legal = 1'b0;
    end
  end

`ifdef ENC_CHECK_EN
  // Flag nonzero bits in fields the chosen format throws away.
  always_comb begin
    discard_nz = 1'b0;
    if (aluop == NOP) begin
      discard_nz = |{op1, op2, immdata};
    end else if (aluop <= SWAP) begin
      discard_nz = |immdata;
    end else if (aluop <= 5'(ALUOP_MAX)) begin
      discard_nz = |op2;
    end
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: FSM, registered output word, write address and word counter.
// Optional macro ENC_CHECK_EN adds the sticky field_warn output.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic [AW:0]     word_count,
  output logic            full,
`ifdef ENC_CHECK_EN
  output logic            field_warn,
`endif
  output logic            err_illegal
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);

  enc_state_e    r_state, w_state_next;
  logic          r_out_valid;
  logic [15:0]   r_out_instr;
  logic [AW-1:0] r_out_addr;
  logic [AW:0]   r_word_count;
  logic          r_err_illegal;

  logic          w_legal;
  logic [15:0]   w_instr;
  logic          w_in_ready;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_last;

`ifdef ENC_CHECK_EN
  logic          w_discard_nz;
  logic          r_field_warn;
`endif

  instr_enc_comb u_comb (
    .aluop      (bus.aluop),
    .op1        (bus.op1),
    .op2        (bus.op2),
    .immdata    (bus.immdata),
`ifdef ENC_CHECK_EN
    .discard_nz (w_discard_nz),
`endif
    .legal      (w_legal),
    .instr      (w_instr)
  );

  assign w_last   = (r_out_addr == LastAddr);
  assign w_out_hs = r_out_valid && bus.out_ready;
  assign w_in_hs  = bus.in_valid && w_in_ready;

  // Next state and input-ready decode.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    unique case (r_state)
      StIdle: if (start) w_state_next = StRun;
      StRun: begin
        // Hold off while the final word is pending: a bundle taken then would have no address.
        w_in_ready = !r_out_valid || (bus.out_ready && !w_last);
        if (start) w_state_next = StRun;
        else if (w_out_hs && w_last) w_state_next = StFull;
      end
      StFull: if (start) w_state_next = StRun;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Output word, address, count and sticky error; start overrides any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_instr   <= '0;
      r_out_addr    <= '0;
      r_word_count  <= '0;
      r_err_illegal <= 1'b0;
    end else if (start) begin
      r_out_valid   <= 1'b0;
      r_out_addr    <= '0;
      r_word_count  <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      if (w_out_hs) begin
        r_word_count <= r_word_count + CntOne;
        if (!w_last) r_out_addr <= r_out_addr + AW'(1);
      end
      if (w_in_hs && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_hs && !w_legal) r_err_illegal <= 1'b1;
    end
  end

`ifdef ENC_CHECK_EN
  // Sticky discarded-field warning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_field_warn <= 1'b0;
    else if (start)                      r_field_warn <= 1'b0;
    else if (w_in_hs && w_discard_nz)    r_field_warn <= 1'b1;
  end
  assign field_warn = r_field_warn;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_addr  = r_out_addr;
  assign word_count    = r_word_count;
  assign full          = (r_state == StFull);
  assign err_illegal   = r_err_illegal;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, AW=2).
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [AW:0] word_count;
  logic        full;
  logic        err_illegal;
`ifdef ENC_CHECK_EN
  logic        field_warn;
`endif

  int errors = 0;
  int checks = 0;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .word_count  (word_count),
    .full        (full),
`ifdef ENC_CHECK_EN
    .field_warn  (field_warn),
`endif
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full-run vectors: aluop, op1, op2, immdata, expected word.
  logic [4:0]  v_aluop [4] = '{5'd0, 5'd16, 5'd19, 5'd30};
  logic [2:0]  v_op1   [4] = '{3'd7, 3'd1, 3'd3, 3'd0};
  logic [2:0]  v_op2   [4] = '{3'd7, 3'd2, 3'd0, 3'd0};
  logic [7:0]  v_imm   [4] = '{8'h00, 8'h00, 8'h12, 8'hFF};
  logic [15:0] v_exp   [4] = '{16'h0000, 16'h048A, 16'h8312, 16'hD8FF};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluop     = '0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.immdata   = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", 32'(bus.out_instr), 32'h0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Register-type word, latency one cycle.
    pulse_start();
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.aluop = 5'd1; bus.op1 = 3'd2; bus.op2 = 3'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_instr", 32'(bus.out_instr), 32'h0053);
    chk("t1_addr", 32'(bus.out_addr), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("t1_drained", 32'(bus.out_valid), 32'd0);
    chk("t1_count", 32'(word_count), 32'd1);
    chk("t1_addr_next", 32'(bus.out_addr), 32'd1);

    // Back-to-back words.
    pulse_start();
    chk("t2_start_count", 32'(word_count), 32'd0);
    chk("t2_start_addr", 32'(bus.out_addr), 32'd0);
    bus.in_valid = 1'b1; bus.aluop = 5'd7; bus.op1 = 3'd1; bus.op2 = 3'd0;
    tick();
    chk("t2_w0_instr", 32'(bus.out_instr), 32'h0208);
    chk("t2_w0_addr", 32'(bus.out_addr), 32'd0);
    bus.aluop = 5'd18; bus.op1 = 3'd7; bus.op2 = 3'd7;
    tick();
    bus.in_valid = 1'b0;
    chk("t2_w1_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_w1_instr", 32'(bus.out_instr), 32'h053F);
    chk("t2_w1_addr", 32'(bus.out_addr), 32'd1);
    tick();
    chk("t2_count", 32'(word_count), 32'd2);
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // Immediate-type word held through a 3-cycle stall.
    pulse_start();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.aluop = 5'd25; bus.op1 = 3'd5; bus.op2 = 3'd0;
    bus.immdata = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_stall_instr", 32'(bus.out_instr), 32'hB5A5);
      chk("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t3_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t3_drained", 32'(bus.out_valid), 32'd0);
    chk("t3_count", 32'(word_count), 32'd1);

    // Illegal aluop consumed without a word; address retained.
    bus.in_valid = 1'b1; bus.aluop = 5'd31; bus.op1 = 3'd1; bus.immdata = 8'h00;
    tick();
    chk("t4_err", 32'(err_illegal), 32'd1);
    chk("t4_no_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_addr_kept", 32'(bus.out_addr), 32'd1);
    bus.aluop = 5'd2; bus.op1 = 3'd0; bus.op2 = 3'd1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_next_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_next_instr", 32'(bus.out_instr), 32'h0081);
    chk("t4_next_addr", 32'(bus.out_addr), 32'd1);
    chk("t4_err_sticky", 32'(err_illegal), 32'd1);
    tick();

    // Fill all DEPTH words, then restart.
    pulse_start();
    chk("t5_err_cleared", 32'(err_illegal), 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.aluop = v_aluop[i]; bus.op1 = v_op1[i]; bus.op2 = v_op2[i]; bus.immdata = v_imm[i];
      tick();
      chk("t5_instr", 32'(bus.out_instr), 32'(v_exp[i]));
      chk("t5_addr", 32'(bus.out_addr), 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_full_count", 32'(word_count), 32'd4);
    chk("t5_full_no_valid", 32'(bus.out_valid), 32'd0);
    pulse_start();
    chk("t5_restart_full", 32'(full), 32'd0);
    chk("t5_restart_addr", 32'(bus.out_addr), 32'd0);
    chk("t5_restart_count", 32'(word_count), 32'd0);

    // Asynchronous reset while a word is pending.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.aluop = 5'd3; bus.op1 = 3'd1; bus.op2 = 3'd1; bus.immdata = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    chk("t6_pending", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_instr", 32'(bus.out_instr), 32'h0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_in_ready", 32'(bus.in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
